// File: rtl/clock_pkg.sv
// Shared encodings, BCD limits and calendar helpers for the clock datapath.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN       = 2'd0,
        MODE_SET_TIME  = 2'd1,
        MODE_SET_DATE  = 2'd2,
        MODE_SET_ALARM = 2'd3
    } clkMode_t;

    typedef enum logic {
        AL_IDLE = 1'b0,
        AL_RING = 1'b1
    } alarmState_t;

    localparam logic [7:0] BCD_ZERO      = 8'h00;
    localparam logic [7:0] BCD_ONE       = 8'h01;
    localparam logic [7:0] BCD_SEC_MAX   = 8'h59;
    localparam logic [7:0] BCD_MIN_MAX   = 8'h59;
    localparam logic [7:0] BCD_HOUR_MAX  = 8'h23;
    localparam logic [7:0] BCD_MONTH_MAX = 8'h12;
    localparam logic [7:0] BCD_ALARM_HH  = 8'h07;

    // Two-digit BCD increment; callers guarantee the value is below 99.
    function automatic logic [7:0] bcdInc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
        else                r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // Month length in BCD, no leap years.
    function automatic logic [7:0] daysInMonth(input logic [7:0] month);
        logic [7:0] d;
        case (month)
            8'h02:                      d = 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: d = 8'h30;
            default:                    d = 8'h31;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/clock_core_editor.sv
// Next value of a BCD hh:mm pair for one edit pulse; lowest set bit wins,
// digits roll over individually with no carry into their neighbours.
module bcd_hhmm_editor (
    input  logic [7:0] hh,
    input  logic [7:0] mm,
    input  logic [3:0] btn,
    output logic [7:0] hhNext,
    output logic [7:0] mmNext
);

    // Apply the single highest-priority digit edit.
    always_comb begin
        hhNext = hh;
        mmNext = mm;
        if (btn[0]) begin
            mmNext[3:0] = (mm[3:0] == 4'd9) ? 4'd0 : mm[3:0] + 4'd1;
        end else if (btn[1]) begin
            mmNext[7:4] = (mm[7:4] == 4'd5) ? 4'd0 : mm[7:4] + 4'd1;
        end else if (btn[2]) begin
            // Hour units stop at 3 in the twenties so 24..29 never appear.
            if ((hh[7:4] == 4'd2 && hh[3:0] == 4'd3) || hh[3:0] == 4'd9)
                hhNext[3:0] = 4'd0;
            else
                hhNext[3:0] = hh[3:0] + 4'd1;
        end else if (btn[3]) begin
            case (hh[7:4])
                4'd0: hhNext[7:4] = 4'd1;
                4'd1: begin
                    hhNext[7:4] = 4'd2;
                    if (hh[3:0] > 4'd3) hhNext[3:0] = 4'd3;
                end
                default: hhNext[7:4] = 4'd0;
            endcase
        end
    end

endmodule

// File: rtl/clock_core.sv
// Timekeeping core: 1 Hz prescaler, BCD time/date/alarm registers, set-mode
// edits and the alarm ring sequencer.
module clock_core
    import clock_pkg::*;
#(
    parameter int MFREQ_KHZ = 1,
    parameter int ALARM_SEC = 60
) (
    input  logic       mclk,
    input  logic       rst,
    input  logic [1:0] clk_mode,
    input  logic [3:0] vButton,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic [7:0] day,
    output logic [7:0] month,
    output logic [7:0] al_hh,
    output logic [7:0] al_mm,
    output logic       alarm_ring,
    output logic       tick_1hz
);

    localparam logic [31:0] PRESC_MAX = 32'(MFREQ_KHZ * 1000 - 1);
    localparam int          CNT_W     = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;

    clkMode_t    mode;
    logic [31:0] presc;
    logic        wrap;
    logic        secWrap, minWrap, hourWrap, midnight, alarmHit;
    logic [7:0]  advSs, advMm, advHh;
    logic [7:0]  curDim, nextMonth, nextDim;
    logic [7:0]  tEdHh, tEdMm, aEdHh, aEdMm;
    alarmState_t alState, alStateNext;
    logic [CNT_W-1:0] ringCnt, ringCntNext;

    assign mode = clkMode_t'(clk_mode);

    // A second elapses when the prescaler wraps; it is held in set-time mode.
    assign wrap = (mode != MODE_SET_TIME) && (presc == PRESC_MAX);

    // Carry chain of a one-second advance.
    assign secWrap  = (ss == BCD_SEC_MAX);
    assign minWrap  = (mm == BCD_MIN_MAX);
    assign hourWrap = (hh == BCD_HOUR_MAX);
    assign advSs    = secWrap ? BCD_ZERO : bcdInc(ss);
    assign advMm    = secWrap ? (minWrap ? BCD_ZERO : bcdInc(mm)) : mm;
    assign advHh    = (secWrap && minWrap) ? (hourWrap ? BCD_ZERO : bcdInc(hh)) : hh;
    assign midnight = wrap && secWrap && minWrap && hourWrap;

    // Ring only when a running tick lands exactly on al_hh:al_mm:00.
    assign alarmHit = wrap && (mode == MODE_RUN) && secWrap &&
                      (advMm == al_mm) && (advHh == al_hh);

    assign curDim    = daysInMonth(month);
    assign nextMonth = (month == BCD_MONTH_MAX) ? BCD_ONE : bcdInc(month);
    assign nextDim   = daysInMonth(nextMonth);

    bcd_hhmm_editor timeEd (
        .hh(hh), .mm(mm), .btn(vButton), .hhNext(tEdHh), .mmNext(tEdMm)
    );

    bcd_hhmm_editor alarmEd (
        .hh(al_hh), .mm(al_mm), .btn(vButton), .hhNext(aEdHh), .mmNext(aEdMm)
    );

    // Prescaler and the registered one-second pulse.
    always_ff @(posedge mclk) begin
        if (rst) begin
            presc    <= '0;
            tick_1hz <= 1'b0;
        end else begin
            presc    <= (mode == MODE_SET_TIME || wrap) ? 32'd0 : presc + 32'd1;
            tick_1hz <= wrap;
        end
    end

    // Time of day: frozen and editable in set-time mode, otherwise counting.
    always_ff @(posedge mclk) begin
        if (rst) begin
            hh <= BCD_ZERO;
            mm <= BCD_ZERO;
            ss <= BCD_ZERO;
        end else if (mode == MODE_SET_TIME) begin
            hh <= tEdHh;
            mm <= tEdMm;
            ss <= BCD_ZERO;
        end else if (wrap) begin
            hh <= advHh;
            mm <= advMm;
            ss <= advSs;
        end
    end

    // Date: edits take priority over a coincident midnight carry.
    always_ff @(posedge mclk) begin
        if (rst) begin
            day   <= BCD_ONE;
            month <= BCD_ONE;
        end else if (mode == MODE_SET_DATE && vButton[0]) begin
            day <= (day == curDim) ? BCD_ONE : bcdInc(day);
        end else if (mode == MODE_SET_DATE && vButton[1]) begin
            month <= nextMonth;
            if (day > nextDim) day <= nextDim;
        end else if (midnight) begin
            if (day == curDim) begin
                day   <= BCD_ONE;
                month <= nextMonth;
            end else begin
                day <= bcdInc(day);
            end
        end
    end

    // Alarm time, editable only in set-alarm mode.
    always_ff @(posedge mclk) begin
        if (rst) begin
            al_hh <= BCD_ALARM_HH;
            al_mm <= BCD_ZERO;
        end else if (mode == MODE_SET_ALARM) begin
            al_hh <= aEdHh;
            al_mm <= aEdMm;
        end
    end

    // Alarm sequencer state register.
    always_ff @(posedge mclk) begin
        if (rst) begin
            alState <= AL_IDLE;
            ringCnt <= '0;
        end else begin
            alState <= alStateNext;
            ringCnt <= ringCntNext;
        end
    end

    // Ring for ALARM_SEC ticks unless a button or a mode change silences it.
    always_comb begin
        alStateNext = alState;
        ringCntNext = ringCnt;
        case (alState)
            AL_IDLE: begin
                if (alarmHit) begin
                    alStateNext = AL_RING;
                    ringCntNext = '0;
                end
            end
            AL_RING: begin
                if (mode != MODE_RUN || (|vButton)) begin
                    alStateNext = AL_IDLE;
                end else if (wrap) begin
                    if (ringCnt == CNT_W'(ALARM_SEC - 1)) alStateNext = AL_IDLE;
                    else                                  ringCntNext = ringCnt + CNT_W'(1);
                end
            end
            default: alStateNext = AL_IDLE;
        endcase
    end

    assign alarm_ring = (alState == AL_RING);

endmodule

// File: tb/tb_clock_core.sv
// Self-checking bench for clock_core against an integer-arithmetic clock model.
module tb_clock_core;

    logic       mclk = 1'b0;
    logic       rst;
    logic [1:0] clk_mode;
    logic [3:0] vButton;
    logic [7:0] hh, mm, ss, day, month, al_hh, al_mm;
    logic       alarm_ring, tick_1hz;
    logic [7:0] hh2, mm2, ss2, day2, month2, al_hh2, al_mm2;
    logic       alarm_ring2, tick2;

    // Short ring so a full timeout fits in the run.
    clock_core #(.MFREQ_KHZ(1), .ALARM_SEC(3)) dut (
        .mclk(mclk), .rst(rst), .clk_mode(clk_mode), .vButton(vButton),
        .hh(hh), .mm(mm), .ss(ss), .day(day), .month(month),
        .al_hh(al_hh), .al_mm(al_mm), .alarm_ring(alarm_ring), .tick_1hz(tick_1hz)
    );

    // Default 60 s ring, same stimulus: used for the button-silence case.
    clock_core #(.MFREQ_KHZ(1), .ALARM_SEC(60)) dut2 (
        .mclk(mclk), .rst(rst), .clk_mode(clk_mode), .vButton(vButton),
        .hh(hh2), .mm(mm2), .ss(ss2), .day(day2), .month(month2),
        .al_hh(al_hh2), .al_mm(al_mm2), .alarm_ring(alarm_ring2), .tick_1hz(tick2)
    );

    always #5 mclk = ~mclk;

    int errors = 0;
    int checks = 0;
    int tickCnt = 0;
    int cycN = 0;
    int mH, mM, aH, aM, dD, dM;
    int dimTab [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

    always @(negedge mclk) if (tick_1hz === 1'b1) tickCnt <= tickCnt + 1;

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge mclk);
            cycN++;
        end
        #1;
    endtask

    task automatic press(input logic [3:0] b);
        vButton = b;
        cyc(1);
        vButton = 4'b0;
        cyc(1);
    endtask

    task automatic editHHMM(inout int h, inout int m, input logic [3:0] b);
        int ht, hu;
        ht = h / 10;
        hu = h % 10;
        if (b[0])      m = (m / 10) * 10 + (m % 10 + 1) % 10;
        else if (b[1]) m = ((m / 10 + 1) % 6) * 10 + m % 10;
        else if (b[2]) begin hu = (ht == 2) ? (hu + 1) % 4 : (hu + 1) % 10; h = ht * 10 + hu; end
        else if (b[3]) begin ht = (ht + 1) % 3; if (ht == 2 && hu > 3) hu = 3; h = ht * 10 + hu; end
    endtask

    task automatic editDate(input logic [3:0] b);
        if (b[0]) dD = (dD >= dimTab[dM-1]) ? 1 : dD + 1;
        else if (b[1]) begin
            dM = dM % 12 + 1;
            if (dD > dimTab[dM-1]) dD = dimTab[dM-1];
        end
    endtask

    task automatic setHHMM(input int th, input int tm, input bit alm);
        int h, m;
        h = alm ? aH : mH;
        m = alm ? aM : mM;
        for (int k = 0; k < 10 && m % 10 != tm % 10; k++) begin press(4'b0001); editHHMM(h, m, 4'b0001); end
        for (int k = 0; k < 6 && m / 10 != tm / 10; k++)  begin press(4'b0010); editHHMM(h, m, 4'b0010); end
        for (int k = 0; k < 3 && h / 10 != th / 10; k++)  begin press(4'b1000); editHHMM(h, m, 4'b1000); end
        for (int k = 0; k < 10 && h % 10 != th % 10; k++) begin press(4'b0100); editHHMM(h, m, 4'b0100); end
        if (alm) begin aH = h; aM = m; end else begin mH = h; mM = m; end
    endtask

    task automatic setDate(input int td, input int tmon);
        for (int k = 0; k < 12 && dM != tmon; k++) begin press(4'b0010); editDate(4'b0010); end
        for (int k = 0; k < 32 && dD != td; k++)   begin press(4'b0001); editDate(4'b0001); end
    endtask

    task automatic test_reset();
        rst = 1'b1; clk_mode = 2'd0; vButton = 4'b0;
        cyc(3);
        rst = 1'b0;
        cyc(1);
        checks++; if ({hh, mm, ss} !== 24'h000000) begin errors++; $display("FAIL reset_time: got %h:%h:%h want 00:00:00", hh, mm, ss); end
        checks++; if ({day, month} !== 16'h0101) begin errors++; $display("FAIL reset_date: got %h/%h want 01/01", day, month); end
        checks++; if ({al_hh, al_mm} !== 16'h0700) begin errors++; $display("FAIL reset_alarm: got %h:%h want 07:00", al_hh, al_mm); end
        checks++; if (alarm_ring !== 1'b0 || tick_1hz !== 1'b0) begin errors++; $display("FAIL reset_flags: ring=%b tick=%b want 0 0", alarm_ring, tick_1hz); end
        mH = 0; mM = 0; aH = 7; aM = 0; dD = 1; dM = 1;
    endtask

    task automatic test_set_time();
        logic [3:0] b;
        int t0;
        clk_mode = 2'd1;
        cyc(1);
        setHHMM(19, 7, 0);
        checks++; if ({hh, mm} !== 16'h1907) begin errors++; $display("FAIL set_time_1907: got %h:%h want 19:07", hh, mm); end
        press(4'b1000); editHHMM(mH, mM, 4'b1000);
        checks++; if (hh !== 8'h23) begin errors++; $display("FAIL tens_clamp: got %h want 23", hh); end
        press(4'b0100); editHHMM(mH, mM, 4'b0100);
        checks++; if (hh !== 8'h20) begin errors++; $display("FAIL units_wrap23: got %h want 20", hh); end
        for (int i = 0; i < 40; i++) begin
            b = 4'($urandom_range(1, 15));
            press(b); editHHMM(mH, mM, b);
            checks++;
            if (hh !== bcd(mH) || mm !== bcd(mM) || ss !== 8'h00) begin
                errors++; $display("FAIL set_time_rand: b=%b got %h:%h:%h want %h:%h:00", b, hh, mm, ss, bcd(mH), bcd(mM));
            end
        end
        t0 = tickCnt;
        cyc(2000);
        checks++; if (ss !== 8'h00 || tickCnt != t0) begin errors++; $display("FAIL set_time_frozen: ss=%h ticks=%0d want 00 0", ss, tickCnt - t0); end
    endtask

    task automatic test_set_date();
        logic [3:0] b;
        clk_mode = 2'd2;
        cyc(1);
        setDate(31, 1);
        checks++; if ({day, month} !== 16'h3101) begin errors++; $display("FAIL date_3101: got %h/%h want 31/01", day, month); end
        press(4'b0010); editDate(4'b0010);
        checks++; if ({day, month} !== 16'h2802) begin errors++; $display("FAIL month_clamp: got %h/%h want 28/02", day, month); end
        press(4'b0001); editDate(4'b0001);
        checks++; if ({day, month} !== 16'h0102) begin errors++; $display("FAIL day_wrap_feb: got %h/%h want 01/02", day, month); end
        press(4'b0011); editDate(4'b0011);
        checks++; if ({day, month} !== 16'h0202) begin errors++; $display("FAIL multi_bit_day: got %h/%h want 02/02", day, month); end
        for (int i = 0; i < 40; i++) begin
            b = 4'($urandom_range(1, 15));
            press(b); editDate(b);
            checks++;
            if (day !== bcd(dD) || month !== bcd(dM)) begin
                errors++; $display("FAIL set_date_rand: b=%b got %h/%h want %h/%h", b, day, month, bcd(dD), bcd(dM));
            end
        end
    endtask

    task automatic test_set_alarm();
        logic [3:0] b;
        clk_mode = 2'd3;
        cyc(1);
        for (int i = 0; i < 40; i++) begin
            b = 4'($urandom_range(1, 15));
            press(b); editHHMM(aH, aM, b);
            checks++;
            if (al_hh !== bcd(aH) || al_mm !== bcd(aM)) begin
                errors++; $display("FAIL set_alarm_rand: b=%b got %h:%h want %h:%h", b, al_hh, al_mm, bcd(aH), bcd(aM));
            end
        end
        setHHMM(23, 59, 1);
        checks++; if ({al_hh, al_mm} !== 16'h2359) begin errors++; $display("FAIL alarm_2359: got %h:%h want 23:59", al_hh, al_mm); end
    endtask

    task automatic test_run_ignores_buttons();
        logic [3:0] b;
        clk_mode = 2'd0;
        cyc(1);
        for (int i = 0; i < 6; i++) begin
            b = 4'($urandom_range(1, 15));
            press(b);
            checks++;
            if (al_hh !== bcd(aH) || al_mm !== bcd(aM) || day !== bcd(dD) || month !== bcd(dM) || alarm_ring !== 1'b0) begin
                errors++; $display("FAIL run_no_edit: b=%b got al %h:%h date %h/%h ring %b", b, al_hh, al_mm, day, month, alarm_ring);
            end
        end
    endtask

    task automatic test_midnight_alarm();
        int start, t0, s, wait_n;
        clk_mode = 2'd2;
        setDate(31, 12);
        checks++; if ({day, month} !== 16'h3112) begin errors++; $display("FAIL date_3112: got %h/%h want 31/12", day, month); end
        clk_mode = 2'd1;
        setHHMM(23, 59, 0);
        cyc(1);
        checks++; if ({hh, mm, ss} !== 24'h235900) begin errors++; $display("FAIL time_235900: got %h:%h:%h", hh, mm, ss); end
        clk_mode = 2'd0;
        start = cycN; t0 = tickCnt;
        cyc(5);
        checks++; if (alarm_ring !== 1'b0 || alarm_ring2 !== 1'b0) begin errors++; $display("FAIL entry_match_ring: got %b %b want 0 0", alarm_ring, alarm_ring2); end
        cyc(995);
        checks++; if (ss !== 8'h01 || tick_1hz !== 1'b1 || tickCnt - t0 != 1) begin
            errors++; $display("FAIL first_tick: ss=%h tick=%b ticks=%0d want 01 1 1", ss, tick_1hz, tickCnt - t0);
        end
        clk_mode = 2'd3;
        setHHMM(0, 0, 1);
        clk_mode = 2'd0;
        checks++; if ({al_hh, al_mm} !== 16'h0000) begin errors++; $display("FAIL alarm_0000: got %h:%h", al_hh, al_mm); end
        wait_n = start + 59999 - cycN;
        cyc(wait_n);
        s = (23 * 3600 + 59 * 60 + 59) % 86400;
        checks++; if (hh !== bcd(s / 3600) || mm !== bcd((s / 60) % 60) || ss !== bcd(s % 60) || {day, month} !== 16'h3112 || alarm_ring !== 1'b0) begin
            errors++; $display("FAIL pre_midnight: got %h:%h:%h %h/%h ring %b", hh, mm, ss, day, month, alarm_ring);
        end
        cyc(1);
        s = (23 * 3600 + 59 * 60 + 60) % 86400;
        checks++; if (hh !== bcd(s / 3600) || mm !== bcd((s / 60) % 60) || ss !== bcd(s % 60)) begin errors++; $display("FAIL midnight_time: got %h:%h:%h want 00:00:00", hh, mm, ss); end
        checks++; if ({day, month} !== 16'h0101) begin errors++; $display("FAIL year_wrap: got %h/%h want 01/01", day, month); end
        checks++; if (tickCnt - t0 != 60 || tick_1hz !== 1'b1) begin errors++; $display("FAIL tick_count: got %0d want 60", tickCnt - t0); end
        checks++; if (alarm_ring !== 1'b1 || alarm_ring2 !== 1'b1) begin errors++; $display("FAIL alarm_start: got %b %b want 1 1", alarm_ring, alarm_ring2); end
        cyc(2000);
        checks++; if (alarm_ring !== 1'b1 || ss !== 8'h02) begin errors++; $display("FAIL alarm_hold: ring=%b ss=%h want 1 02", alarm_ring, ss); end
        cyc(1000);
        checks++; if (alarm_ring !== 1'b0 || alarm_ring2 !== 1'b1) begin errors++; $display("FAIL alarm_timeout: got %b %b want 0 1", alarm_ring, alarm_ring2); end
        cyc(500);
        vButton = 4'b0001;
        cyc(1);
        vButton = 4'b0000;
        checks++; if (alarm_ring2 !== 1'b0) begin errors++; $display("FAIL button_silence: got %b want 0", alarm_ring2); end
        checks++; if ({hh2, mm2, ss2} !== 24'h000003 || {day2, month2} !== 16'h0101 || {al_hh2, al_mm2} !== 16'h0000) begin
            errors++; $display("FAIL silence_no_edit: got %h:%h:%h %h/%h al %h:%h", hh2, mm2, ss2, day2, month2, al_hh2, al_mm2);
        end
    endtask

    task automatic test_reset_midop();
        clk_mode = 2'd3;
        press(4'b0001);
        rst = 1'b1;
        cyc(1);
        checks++; if ({hh, mm, ss, day, month, al_hh, al_mm} !== 56'h000000_0101_0700) begin
            errors++; $display("FAIL reset_midop_regs: got %h:%h:%h %h/%h al %h:%h", hh, mm, ss, day, month, al_hh, al_mm);
        end
        checks++; if (alarm_ring !== 1'b0 || tick_1hz !== 1'b0 || tick2 !== 1'b0) begin
            errors++; $display("FAIL reset_midop_flags: ring=%b tick=%b tick2=%b", alarm_ring, tick_1hz, tick2);
        end
        rst = 1'b0;
        clk_mode = 2'd0;
        cyc(2);
    endtask

    initial begin
        rst = 1'b1; clk_mode = 2'd0; vButton = 4'b0;
        test_reset();
        test_set_time();
        test_set_date();
        test_set_alarm();
        test_run_ignores_buttons();
        test_midnight_alarm();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
